demux1x32_reg: RTL and testbench
================================

Name: demux1x32_reg

Overview:
- Registered 1-to-32 demultiplexer; the routing counterpart of mux32x1, with the same 32 ports and 5-bit select.
- Mux32x1 gathers 32 operand sources into one PE input. This block steers one PE result stream to one of 32 interconnect destinations.
- Single-entry output stage with valid/ready handshake on the input and on each of the 32 outputs.

Parameters:
- WIDTH, 16, data width of every lane.
- NUM_OUT, 32, output lane count; fixed at 32, parameterised only so the shared constants can be reused.
- SEL_W, 5, select width; must equal log2(NUM_OUT).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  payload.
- in_sel  in  SEL_W  destination lane; sampled with in_data on accept.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts this cycle.
- in_bcast  in  1  broadcast request; used only when DEMUX_BCAST_EN is defined, ignored otherwise.
- out_data  out  WIDTH  registered payload, shared by all lanes.
- out_valid  out  NUM_OUT  per-lane valid.
- out_ready  in  NUM_OUT  per-lane ready.
- busy  out  1  stage holds an undelivered word.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid = 0, out_data = 0, busy = 0, state = EMPTY, pending mask = 0.
  - in_ready = 1 as soon as rst deasserts.
- Accept: fires when in_valid && in_ready. On the next clock edge, out_data <= in_data and sel_q <= in_sel. Latency is one cycle, from accept to out_valid asserted.
- State EMPTY:
  - in_ready = 1.
  - Accept moves to FULL and sets out_valid = onehot(in_sel).
- State FULL:
  - out_valid = onehot(sel_q).
  - Delivery occurs when out_ready[sel_q] = 1.
  - in_ready = out_ready[sel_q]. This is the pass-through: a delivery and a new accept can happen in the same cycle, giving full throughput of one word per cycle.
  - Delivery with no new accept returns to EMPTY and clears out_valid.
  - Delivery plus accept stays in FULL, with out_valid = onehot(new sel) on the next cycle.
  - out_ready on non-selected lanes is ignored.
- Stability: while out_valid is set and the word is undelivered, out_data and out_valid must not change.
- in_ready never depends on in_valid, so there is no combinational loop.
- busy = (state != EMPTY).
- rst asserted mid-transfer drops the held word. Outputs go to their reset values immediately, without waiting for a clock edge.
- Every SEL_W value is a legal lane. There is no out-of-range case.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- Defined:
  - Accept with in_bcast = 1 enters state BCAST with pending = all ones and out_valid = pending.
  - Each cycle, pending <= pending & ~out_ready. Lanes that were ready drop their valid on the next cycle.
  - in_ready = 0 while in BCAST, except in the cycle where (pending & ~out_ready) == 0. That cycle allows the same pass-through rules as FULL.
  - Transition out of BCAST when the last lanes complete goes to EMPTY, or to FULL/BCAST if a new word is accepted in that cycle.
- Undefined:
  - No BCAST state and no pending register.
  - in_bcast is unused, with a lint waiver.

Decomposition:
- Shared header demux_defs.vh holds:
  - constants NUM_OUT = 32 and SEL_W = 5, shared with mux32x1 users;
  - state encodings ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_BCAST = 2'd2.
- One sub-module: dec5to32, a combinational binary-to-one-hot decoder used for out_valid and for out_ready[sel_q] gating.

Test Plan:
- Reset: assert rst mid-FULL with sel_q = 7 -> out_valid = 0 and busy = 0 in the same cycle, without a clock edge; in_ready = 1 after release.
- Single word: in_data = 16'hA5A5, in_sel = 3, out_ready = all ones -> next cycle out_valid = 32'h0000_0008, out_data = A5A5; one cycle later out_valid = 0.
- Backpressure: in_sel = 31, out_ready[31] = 0 for 5 cycles -> out_valid[31] and out_data held stable, in_ready = 0; word delivered on the cycle out_ready[31] rises.
- Streaming: 32 back-to-back words with sel = 0..31, all lanes ready -> 32 deliveries in 33 cycles, in_ready held at 1, each word lands on its matching lane.
- Non-selected ready: sel = 4, out_ready = 32'hFFFF_FFEF -> word stays held and in_ready = 0.
- DEMUX_BCAST_EN: broadcast 16'h1234; odd lanes ready in cycle 1, even lanes ready in cycle 3 -> out_valid = 32'h5555_5555 after cycle 1, returns to EMPTY after cycle 3, in_ready = 1 only in that final cycle.

Source files
------------

// File: rtl/demux1x32_reg_pkg.sv
// Shared constants and state encoding for the registered 1-to-32 demultiplexer.
// Lane count and select width match the mux32x1 operand side.
package demux1x32_reg_pkg;

  localparam int DEMUX_NUM_OUT = 32;
  localparam int DEMUX_SEL_W   = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BCAST = 2'd2
  } state_t;

endpackage

// File: rtl/demux1x32_reg_dec5to32.sv
// Combinational binary-to-one-hot decoder (5-bit select to 32 lanes).
module dec5to32
  import demux1x32_reg_pkg::*;
#(
  parameter int SEL_W   = DEMUX_SEL_W,
  parameter int NUM_OUT = DEMUX_NUM_OUT
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux1x32_reg.sv
// Registered 1-to-32 demultiplexer with a single-entry output stage and valid/ready on every lane.
// Optional broadcast to all lanes is compiled in with DEMUX_BCAST_EN.
module demux1x32_reg
  import demux1x32_reg_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = DEMUX_NUM_OUT,
  parameter int SEL_W   = DEMUX_SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bcast,
  output logic [WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic               busy
);

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_OUT-1:0] in_onehot;
  logic [NUM_OUT-1:0] sel_onehot_q;
  logic               sel_ready;
  logic               accept;

  dec5to32 #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec_in (
    .sel    (in_sel),
    .onehot (in_onehot)
  );

  dec5to32 #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec_q (
    .sel    (sel_q),
    .onehot (sel_onehot_q)
  );

  assign sel_ready = |(out_ready & sel_onehot_q);

`ifdef DEMUX_BCAST_EN
  logic [NUM_OUT-1:0] pending;
  logic [NUM_OUT-1:0] pending_nxt;
  assign pending_nxt = pending & ~out_ready;
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;
`endif

  // in_ready is a function of state and out_ready only, never in_valid
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_EMPTY: in_ready = 1'b1;
      ST_FULL:  in_ready = sel_ready;
`ifdef DEMUX_BCAST_EN
      ST_BCAST: in_ready = (pending_nxt == '0);
`endif
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state != ST_EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      sel_q     <= '0;
      out_data  <= '0;
      out_valid <= '0;
`ifdef DEMUX_BCAST_EN
      pending   <= '0;
`endif
    end else if (accept) begin
      // An accept in FULL/BCAST implies the held word leaves this same cycle
      out_data <= in_data;
      sel_q    <= in_sel;
`ifdef DEMUX_BCAST_EN
      if (in_bcast) begin
        state     <= ST_BCAST;
        pending   <= '1;
        out_valid <= '1;
      end else
`endif
      begin
        state     <= ST_FULL;
        out_valid <= in_onehot;
      end
    end else begin
      case (state)
        ST_FULL: begin
          if (sel_ready) begin
            state     <= ST_EMPTY;
            out_valid <= '0;
          end
        end
`ifdef DEMUX_BCAST_EN
        ST_BCAST: begin
          pending   <= pending_nxt;
          out_valid <= pending_nxt;
          if (pending_nxt == '0) state <= ST_EMPTY;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_demux1x32_reg.sv
// Self-checking bench for demux1x32_reg: vector table, corner sequences and a randomized model run.
// Broadcast sequence is included when DEMUX_BCAST_EN is defined.
module tb_demux1x32_reg;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [4:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        in_bcast;
  logic [15:0] out_data;
  logic [31:0] out_valid;
  logic [31:0] out_ready;
  logic        busy;

  int pass_cnt;
  int total_cnt;

  demux1x32_reg #(.WIDTH(16), .NUM_OUT(32), .SEL_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcast  (in_bcast),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [4:0]  in_sel;
    logic [15:0] in_data;
    logic [31:0] out_ready;
    logic        exp_in_ready;
    logic [31:0] exp_out_valid;
    logic        chk_data;
    logic [15:0] exp_out_data;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [10];

  task automatic applyStimulus(input logic v, input logic [4:0] s, input logic [15:0] d,
                               input logic [31:0] r, input logic b);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    in_bcast  = b;
  endtask

  task automatic cmp(input string tag, input string what, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("[TB] FAIL %s %s: got %h want %h", tag, what, got, want);
  endtask

  task automatic checkOutput(input string tag, input logic exp_ir, input logic [31:0] exp_ov,
                             input logic chk_data, input logic [15:0] exp_d, input logic exp_busy);
    cmp(tag, "in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    cmp(tag, "out_valid", out_valid, exp_ov);
    cmp(tag, "busy", {31'd0, busy}, {31'd0, exp_busy});
    if (chk_data) cmp(tag, "out_data", {16'd0, out_data}, {16'd0, exp_d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one held word (or none), described by lane and payload
  logic        m_held;
  logic [4:0]  m_lane;
  logic [15:0] m_data;

  initial begin
    int deliveries;
    logic        exp_ir;
    logic [31:0] exp_ov;
    logic [15:0] fk;
    pass_cnt  = 0;
    total_cnt = 0;

    // Each row: inputs applied for one cycle, outputs expected just before the next edge
    tbl[0] = '{1'b1, 5'd3, 16'hA5A5, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 16'h0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0008, 1'b1, 16'hA5A5, 1'b1};
    tbl[2] = '{1'b0, 5'd0, 16'h0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 16'h0000, 1'b0};
    tbl[3] = '{1'b1, 5'd4, 16'h0404, 32'hFFFF_FFEF, 1'b1, 32'h0000_0000, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 5'd0, 16'h0000, 32'hFFFF_FFEF, 1'b0, 32'h0000_0010, 1'b1, 16'h0404, 1'b1};
    tbl[5] = '{1'b1, 5'd9, 16'hBEEF, 32'hFFFF_FFEF, 1'b0, 32'h0000_0010, 1'b1, 16'h0404, 1'b1};
    tbl[6] = '{1'b1, 5'd9, 16'hBEEF, 32'h0000_0010, 1'b1, 32'h0000_0010, 1'b1, 16'h0404, 1'b1};
    tbl[7] = '{1'b0, 5'd0, 16'h0000, 32'h0000_0000, 1'b0, 32'h0000_0200, 1'b1, 16'hBEEF, 1'b1};
    tbl[8] = '{1'b0, 5'd0, 16'h0000, 32'h0000_0200, 1'b1, 32'h0000_0200, 1'b1, 16'hBEEF, 1'b1};
    tbl[9] = '{1'b0, 5'd0, 16'h0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 16'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("reset", 1'b1, 32'h0, 1'b1, 16'h0000, 1'b0);
    tick();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].in_valid, tbl[i].in_sel, tbl[i].in_data, tbl[i].out_ready, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d", i), tbl[i].exp_in_ready, tbl[i].exp_out_valid,
                  tbl[i].chk_data, tbl[i].exp_out_data, tbl[i].exp_busy);
      tick();
    end

    // Backpressure on lane 31 for five cycles, then delivery
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k == 0, 5'd31, 16'h3131, (k == 6) ? 32'h8000_0000 : 32'h0, 1'b0);
      @(negedge clk);
      if (k == 0)      checkOutput("bp_load", 1'b1, 32'h0, 1'b0, 16'h0, 1'b0);
      else if (k < 7)  checkOutput($sformatf("bp%0d", k), k == 6, 32'h8000_0000, 1'b1, 16'h3131, 1'b1);
      else             checkOutput("bp_done", 1'b1, 32'h0, 1'b0, 16'h0, 1'b0);
      tick();
    end

    // Streaming: 32 back-to-back words, one per lane
    deliveries = 0;
    for (int k = 0; k < 33; k++) begin
      fk = 16'(k * 16'h0101 + 16'h0011);
      applyStimulus(k < 32, 5'(k), fk, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      if (|(out_valid & out_ready)) deliveries++;
      if (k == 0) checkOutput("stream0", 1'b1, 32'h0, 1'b0, 16'h0, 1'b0);
      else checkOutput($sformatf("stream%0d", k), 1'b1, 32'h1 << (k - 1), 1'b1,
                       16'((k - 1) * 16'h0101 + 16'h0011), 1'b1);
      tick();
    end
    cmp("stream", "deliveries", deliveries, 32);
    applyStimulus(1'b0, 5'd0, 16'h0, 32'hFFFF_FFFF, 1'b0);
    tick();

    // Asynchronous reset while holding a word on lane 7
    applyStimulus(1'b1, 5'd7, 16'h0707, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 16'h0, 32'h0, 1'b0);
    checkOutput("rst_pre", 1'b0, 32'h0000_0080, 1'b1, 16'h0707, 1'b1);
    #2 rst = 1'b1;
    #1 checkOutput("rst_async", 1'b1, 32'h0, 1'b1, 16'h0000, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("rst_release", 1'b1, 32'h0, 1'b0, 16'h0, 1'b0);
    tick();

`ifdef DEMUX_BCAST_EN
    // Broadcast: odd lanes take it first, even lanes two cycles later
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 0, 5'd0, 16'h1234,
                    (k == 1) ? 32'hAAAA_AAAA : (k == 3) ? 32'h5555_5555 : 32'h0, k == 0);
      @(negedge clk);
      case (k)
        0: checkOutput("bc0", 1'b1, 32'h0, 1'b0, 16'h0, 1'b0);
        1: checkOutput("bc1", 1'b0, 32'hFFFF_FFFF, 1'b1, 16'h1234, 1'b1);
        2: checkOutput("bc2", 1'b0, 32'h5555_5555, 1'b1, 16'h1234, 1'b1);
        3: checkOutput("bc3", 1'b1, 32'h5555_5555, 1'b1, 16'h1234, 1'b1);
        default: checkOutput("bc4", 1'b1, 32'h0, 1'b0, 16'h0, 1'b0);
      endcase
      tick();
    end
`endif

    // Randomized traffic against the held-word model
    m_held = 1'b0;
    m_lane = '0;
    m_data = '0;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] r;
      case ($urandom_range(0, 2))
        0:       r = 32'hFFFF_FFFF;
        1:       r = $urandom;
        default: r = 32'h0;
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 16'($urandom), r, 1'b0);
      @(negedge clk);
      exp_ir = !m_held || out_ready[m_lane];
      exp_ov = m_held ? (32'h1 << m_lane) : 32'h0;
      checkOutput($sformatf("rand%0d", k), exp_ir, exp_ov, m_held, m_data, m_held);
      if (in_valid && exp_ir) begin
        m_held = 1'b1;
        m_lane = in_sel;
        m_data = in_data;
      end else if (m_held && out_ready[m_lane]) begin
        m_held = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
